// File: rtl/rv_pkg.sv
// Shared RV32 definitions: fetch FSM states, architectural widths and the
// fetch-address legality check reused by the instruction and data-memory controllers.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    // Word-aligned and fully inside a memory of mem_bytes bytes. Comparing
    // against mem_bytes-4 rather than addr+4 keeps the check immune to 32-bit wrap.
    function automatic logic legal(input logic [XLEN-1:0] addr,
                                   input logic [XLEN-1:0] mem_bytes);
        return (addr[1:0] == 2'b00) && (addr <= (mem_bytes - XLEN'(INST_BYTES)));
    endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Instruction-memory, redirect/halt and fetch/decode slot signals of the fetch sequencer.
interface ifetch_ctrl_if;
    import rv_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_inst;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            halt_req;
    logic            fd_valid;
    logic            fd_ready;
    logic [XLEN-1:0] fd_pc;
    logic [XLEN-1:0] fd_inst;
    logic [XLEN-1:0] fd_pc_plus4;
    logic            fault;
    logic [XLEN-1:0] fault_addr;
    logic [XLEN-1:0] fetch_count;
    fetch_state_e    state;

    modport master (
        output imem_addr, fd_valid, fd_pc, fd_inst, fd_pc_plus4,
               fault, fault_addr, fetch_count, state,
        input  imem_inst, redirect_valid, redirect_target, halt_req, fd_ready
    );

    modport slave (
        input  imem_addr, fd_valid, fd_pc, fd_inst, fd_pc_plus4,
               fault, fault_addr, fetch_count, state,
        output imem_inst, redirect_valid, redirect_target, halt_req, fd_ready
    );

endinterface

// File: rtl/ifetch_ctrl.sv
// RV32 instruction-fetch sequencer: owns the PC, fills a single-entry fetch/decode
// slot from combinational instruction memory, applies redirects/halts, traps bad addresses.
module ifetch_ctrl
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    ifetch_ctrl_if.master bus
);

    fetch_state_e    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            fd_valid, fd_valid_n;
    logic [XLEN-1:0] fd_pc, fd_pc_n;
    logic [XLEN-1:0] fd_inst, fd_inst_n;
    logic [XLEN-1:0] fd_pc_plus4, fd_pc_plus4_n;
    logic [XLEN-1:0] fault_addr, fault_addr_n;
    logic [XLEN-1:0] fetch_count, fetch_count_n;

    logic slot_free;
    logic handshake;
    logic pc_legal;
    logic target_legal;

    assign slot_free    = !fd_valid || bus.fd_ready;
    assign handshake    = fd_valid && bus.fd_ready;
    assign pc_legal     = legal(pc, XLEN'(IMEM_BYTES));
    assign target_legal = legal(bus.redirect_target, XLEN'(IMEM_BYTES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            fd_valid    <= 1'b0;
            fd_pc       <= '0;
            fd_inst     <= '0;
            fd_pc_plus4 <= '0;
            fault_addr  <= '0;
            fetch_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            fd_valid    <= fd_valid_n;
            fd_pc       <= fd_pc_n;
            fd_inst     <= fd_inst_n;
            fd_pc_plus4 <= fd_pc_plus4_n;
            fault_addr  <= fault_addr_n;
            fetch_count <= fetch_count_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        fd_valid_n    = fd_valid;
        fd_pc_n       = fd_pc;
        fd_inst_n     = fd_inst;
        fd_pc_plus4_n = fd_pc_plus4;
        fault_addr_n  = fault_addr;
        fetch_count_n = fetch_count;

        case (state)
            RUN, HALT: begin
                if (bus.redirect_valid) begin
                    // A redirect squashes the slot outright; that entry never counts as delivered.
                    fd_valid_n = 1'b0;
                    if (target_legal) begin
                        pc_n = bus.redirect_target;
                        if (state == RUN && bus.halt_req) begin
                            state_n = HALT;
                        end
                    end else begin
                        state_n      = FAULT;
                        fault_addr_n = bus.redirect_target;
                    end
                end else begin
                    if (handshake) begin
                        fetch_count_n = fetch_count + 32'd1;
                        fd_valid_n    = 1'b0;
                    end
                    if (state == HALT) begin
                        if (!bus.halt_req) begin
                            state_n = RUN;
                        end
                    end else if (bus.halt_req) begin
                        state_n = HALT;
                    end else if (slot_free) begin
                        if (pc_legal) begin
                            fd_valid_n    = 1'b1;
                            fd_pc_n       = pc;
                            fd_inst_n     = bus.imem_inst;
                            fd_pc_plus4_n = pc + 32'd4;
                            pc_n          = pc + 32'd4;
                        end else begin
                            state_n      = FAULT;
                            fault_addr_n = pc;
                            fd_valid_n   = 1'b0;
                        end
                    end
                end
            end
            default: begin
                fd_valid_n = 1'b0;
            end
        endcase
    end

    assign bus.imem_addr   = pc;
    assign bus.fd_valid    = fd_valid;
    assign bus.fd_pc       = fd_pc;
    assign bus.fd_inst     = fd_inst;
    assign bus.fd_pc_plus4 = fd_pc_plus4;
    assign bus.fault       = (state == FAULT);
    assign bus.fault_addr  = fault_addr;
    assign bus.fetch_count = fetch_count;
    assign bus.state       = state;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a rule-level model of the fetch sequencer.
module tb_ifetch_ctrl;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic rst16_n;
    always #5 clk = ~clk;

    ifetch_ctrl_if ifc ();
    ifetch_ctrl_if ifc16 ();

    ifetch_ctrl #(.RESET_PC(32'h0), .IMEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc)
    );
    ifetch_ctrl #(.RESET_PC(32'h0), .IMEM_BYTES(16)) dut16 (
        .clk(clk), .rst_n(rst16_n), .bus(ifc16)
    );

    logic [31:0] mem [256];
    assign ifc.imem_inst   = mem[ifc.imem_addr[9:2]];
    assign ifc16.imem_inst = mem[ifc16.imem_addr[9:2]];

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a <= 32'd1020);
    endfunction

    // Rule-level reference: what the slot, PC and status must be after each edge.
    logic [31:0] m_pc, m_st, m_fpc, m_fi, m_fa, m_cnt;
    logic        m_fdv;

    always @(posedge clk) begin : model
        logic [31:0] pc, st, fpc, fi, fa, cnt;
        logic        fdv;
        pc = m_pc; st = m_st; fpc = m_fpc; fi = m_fi; fa = m_fa; cnt = m_cnt; fdv = m_fdv;
        if (!rst_n) begin
            pc = 0; st = 0; fpc = 0; fi = 0; fa = 0; cnt = 0; fdv = 0;
        end else if (st != 2) begin
            if (ifc.redirect_valid) begin
                fdv = 0;
                if (m_legal(ifc.redirect_target)) begin
                    pc = ifc.redirect_target;
                    if (st == 0 && ifc.halt_req) st = 1;
                end else begin
                    st = 2;
                    fa = ifc.redirect_target;
                end
            end else begin
                if (m_fdv && ifc.fd_ready) begin
                    cnt = cnt + 1;
                    fdv = 0;
                end
                if (st == 1) begin
                    if (!ifc.halt_req) st = 0;
                end else if (ifc.halt_req) begin
                    st = 1;
                end else if (!m_fdv || ifc.fd_ready) begin
                    if (m_legal(pc)) begin
                        fdv = 1; fpc = pc; fi = mem[pc / 4]; pc = pc + 4;
                    end else begin
                        st = 2; fa = pc; fdv = 0;
                    end
                end
            end
        end
        m_pc <= pc; m_st <= st; m_fpc <= fpc; m_fi <= fi; m_fa <= fa; m_cnt <= cnt; m_fdv <= fdv;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_addr", ifc.imem_addr, m_pc);
            chk("fd_valid", {31'b0, ifc.fd_valid}, {31'b0, m_fdv});
            chk("state", {30'b0, ifc.state}, m_st);
            chk("fault", {31'b0, ifc.fault}, {31'b0, (m_st == 2)});
            chk("fault_addr", ifc.fault_addr, m_fa);
            chk("fetch_count", ifc.fetch_count, m_cnt);
            if (m_fdv) begin
                chk("fd_pc", ifc.fd_pc, m_fpc);
                chk("fd_inst", ifc.fd_inst, m_fi);
                chk("fd_pc_plus4", ifc.fd_pc_plus4, m_fpc + 32'd4);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] w [5];

    initial begin
        w = '{32'h00A98933, 32'hFCE08793, 32'h00E12423, 32'h00812703, 32'hEDAB3537};
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 5; i++) mem[i] = w[i];

        rst_n = 0; rst16_n = 0;
        ifc.redirect_valid = 0; ifc.redirect_target = 0; ifc.halt_req = 0; ifc.fd_ready = 0;
        ifc16.redirect_valid = 0; ifc16.redirect_target = 0; ifc16.halt_req = 0; ifc16.fd_ready = 1;
        cyc();
        chk_en = 1;
        cyc();
        chk("rst fd_valid", {31'b0, ifc.fd_valid}, 32'd0);
        chk("rst fetch_count", ifc.fetch_count, 32'd0);
        chk("rst state", {30'b0, ifc.state}, 32'd0);
        chk("rst fd_pc", ifc.fd_pc, 32'd0);
        chk("rst imem_addr", ifc.imem_addr, 32'd0);

        // Straight-line delivery at one instruction per cycle
        rst_n = 1; ifc.fd_ready = 1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("line fd_pc", ifc.fd_pc, 32'(k * 4));
            chk("line fd_inst", ifc.fd_inst, w[k]);
        end
        cyc();
        chk("line count", ifc.fetch_count, 32'd5);

        // Backpressure at fd_pc=8
        rst_n = 0; cyc(); rst_n = 1;
        cyc(); cyc(); cyc();
        chk("bp fd_pc", ifc.fd_pc, 32'd8);
        ifc.fd_ready = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("bp fd_inst", ifc.fd_inst, 32'h00E12423);
            chk("bp pc", ifc.imem_addr, 32'd12);
            chk("bp count", ifc.fetch_count, 32'd2);
        end
        ifc.fd_ready = 1;
        cyc();
        chk("bp release fd_pc", ifc.fd_pc, 32'd12);

        // Redirect to 4 while slot holds pc 12
        ifc.redirect_valid = 1; ifc.redirect_target = 32'd4;
        cyc();
        ifc.redirect_valid = 0;
        chk("redir squash", {31'b0, ifc.fd_valid}, 32'd0);
        chk("redir count", ifc.fetch_count, 32'd3);
        cyc();
        chk("redir fd_pc", ifc.fd_pc, 32'd4);
        chk("redir fd_inst", ifc.fd_inst, 32'hFCE08793);

        // Misaligned redirect traps; fault absorbs further redirects
        ifc.redirect_valid = 1; ifc.redirect_target = 32'h6;
        cyc();
        chk("mis state", {30'b0, ifc.state}, 32'd2);
        chk("mis fault", {31'b0, ifc.fault}, 32'd1);
        chk("mis fault_addr", ifc.fault_addr, 32'h6);
        chk("mis fd_valid", {31'b0, ifc.fd_valid}, 32'd0);
        ifc.redirect_target = 32'h0;
        cyc();
        ifc.redirect_valid = 0;
        chk("mis frozen pc", ifc.imem_addr, 32'd8);
        chk("mis still fault", {30'b0, ifc.state}, 32'd2);
        rst_n = 0; cyc(); rst_n = 1;
        cyc();
        chk("mis refetch fd_pc", ifc.fd_pc, 32'd0);
        chk("mis refetch valid", {31'b0, ifc.fd_valid}, 32'd1);

        // Halt with slot at pc 4
        cyc();
        chk("halt fd_pc", ifc.fd_pc, 32'd4);
        ifc.halt_req = 1;
        cyc();
        chk("halt state", {30'b0, ifc.state}, 32'd1);
        chk("halt fd_valid", {31'b0, ifc.fd_valid}, 32'd0);
        cyc();
        chk("halt pc", ifc.imem_addr, 32'd8);
        ifc.halt_req = 0;
        cyc();
        cyc();
        chk("halt resume fd_pc", ifc.fd_pc, 32'd8);
        chk("halt resume valid", {31'b0, ifc.fd_valid}, 32'd1);

        // Sequential overrun on a 16-byte memory
        rst16_n = 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("ovr fd_pc", ifc16.fd_pc, 32'(k * 4));
            chk("ovr fd_inst", ifc16.fd_inst, w[k]);
        end
        cyc();
        chk("ovr state", {30'b0, ifc16.state}, 32'd2);
        chk("ovr fault_addr", ifc16.fault_addr, 32'd16);
        chk("ovr fd_valid", {31'b0, ifc16.fd_valid}, 32'd0);
        chk("ovr count", ifc16.fetch_count, 32'd4);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int r;
            ifc.fd_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) ifc.halt_req = ~ifc.halt_req;
            ifc.redirect_valid = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 9);
            if (r < 7)       ifc.redirect_target = 32'($urandom_range(0, 255)) * 4;
            else if (r == 7) ifc.redirect_target = ($urandom_range(0, 1) != 0) ? 32'd1020 : 32'd1016;
            else if (r == 8) ifc.redirect_target = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
            else             ifc.redirect_target = 32'd1024 + 32'($urandom_range(0, 1000)) * 4;
            rst_n = !((m_st == 2 && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
